// File: rtl/mimo_input_sequencer.sv
// Input sequencer for the MIMO detector: buffers upstream words, enforces channel/data frame order.
// Optional macro SEQ_STALL_CNT_EN builds a saturating backpressure stall counter on stall_cnt.
module mimo_input_sequencer #(
  parameter int I_WIDTH        = 16,
  parameter int DATA_W         = I_WIDTH*8,
  parameter int FIFO_DEPTH     = 4,
  parameter int NUM_CH_WORDS   = 4,
  parameter int FRAME_DATA_LEN = 11
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic              wr_flag,
  input  logic [DATA_W-1:0] wr_data,
  output logic              o_in_valid,
  output logic              o_flag,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_in_ready,
  output logic              frame_done,
  output logic              err,
  output logic [7:0]        frame_cnt,
  output logic [15:0]       stall_cnt
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam int CH_W  = $clog2(NUM_CH_WORDS + 1);
  localparam int DC_W  = $clog2(FRAME_DATA_LEN + 1);

  typedef enum logic {S_CHAN, S_DATA} state_t;

  logic [DATA_W:0]   mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              wr_ready_q, wr_ready_d;
  state_t            state_q, state_d;
  logic [CH_W-1:0]   ch_cnt_q, ch_cnt_d;
  logic [DC_W-1:0]   data_cnt_q, data_cnt_d;
  logic              out_valid_q, out_valid_d;
  logic              out_flag_q, out_flag_d;
  logic [DATA_W-1:0] out_data_q, out_data_d;
  logic              out_last_q, out_last_d;
  logic              frame_done_q, frame_done_d;
  logic              err_q, err_d;
  logic [7:0]        frame_cnt_q, frame_cnt_d;

  logic              wr_en, pop, xfer, fwd, last_word;
  logic              head_flag;
  logic [DATA_W-1:0] head_data;

  // FIFO storage holds {flag, data}; only the pointers and count are reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= {wr_flag, wr_data};
  end

  always_comb begin
    head_flag    = mem_q[rd_ptr_q][DATA_W];
    head_data    = mem_q[rd_ptr_q][DATA_W-1:0];
    xfer         = out_valid_q && i_in_ready;
    wr_en        = wr_valid && wr_ready_q;
    pop          = (count_q != '0) && (!out_valid_q || xfer);
    fwd          = 1'b1;
    last_word    = 1'b0;
    state_d      = state_q;
    ch_cnt_d     = ch_cnt_q;
    data_cnt_d   = data_cnt_q;
    out_valid_d  = out_valid_q && !xfer;
    out_flag_d   = out_flag_q;
    out_data_d   = out_data_q;
    out_last_d   = out_last_q;
    err_d        = 1'b0;
    frame_done_d = xfer && out_last_q;
    frame_cnt_d  = frame_cnt_q + {7'd0, frame_done_d};

    // Order check happens as the head word moves into the output register.
    if (pop) begin
      case (state_q)
        S_CHAN: begin
          if (head_flag) begin
            if (ch_cnt_q == CH_W'(NUM_CH_WORDS - 1)) begin
              state_d    = S_DATA;
              ch_cnt_d   = '0;
              data_cnt_d = '0;
            end else begin
              ch_cnt_d = ch_cnt_q + CH_W'(1);
            end
          end else begin
            fwd   = 1'b0;
            err_d = 1'b1;
          end
        end
        default: begin
          if (!head_flag) begin
            if (data_cnt_q == DC_W'(FRAME_DATA_LEN - 1)) begin
              last_word  = 1'b1;
              state_d    = S_CHAN;
              data_cnt_d = '0;
              ch_cnt_d   = '0;
            end else begin
              data_cnt_d = data_cnt_q + DC_W'(1);
            end
          end else begin
            // Early channel word restarts the frame as its first channel word.
            err_d      = 1'b1;
            data_cnt_d = '0;
            if (NUM_CH_WORDS == 1) begin
              state_d  = S_DATA;
              ch_cnt_d = '0;
            end else begin
              state_d  = S_CHAN;
              ch_cnt_d = CH_W'(1);
            end
          end
        end
      endcase
      if (fwd) begin
        out_valid_d = 1'b1;
        out_flag_d  = head_flag;
        out_data_d  = head_data;
        out_last_d  = last_word;
      end
    end

    wr_ptr_d   = wr_ptr_q + PTR_W'(wr_en);
    rd_ptr_d   = rd_ptr_q + PTR_W'(pop);
    count_d    = count_q + CNT_W'(wr_en) - CNT_W'(pop);
    wr_ready_d = (count_d != CNT_W'(FIFO_DEPTH));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      wr_ready_q   <= 1'b1;
      state_q      <= S_CHAN;
      ch_cnt_q     <= '0;
      data_cnt_q   <= '0;
      out_valid_q  <= 1'b0;
      out_flag_q   <= 1'b0;
      out_data_q   <= '0;
      out_last_q   <= 1'b0;
      frame_done_q <= 1'b0;
      err_q        <= 1'b0;
      frame_cnt_q  <= '0;
    end else begin
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      wr_ready_q   <= wr_ready_d;
      state_q      <= state_d;
      ch_cnt_q     <= ch_cnt_d;
      data_cnt_q   <= data_cnt_d;
      out_valid_q  <= out_valid_d;
      out_flag_q   <= out_flag_d;
      out_data_q   <= out_data_d;
      out_last_q   <= out_last_d;
      frame_done_q <= frame_done_d;
      err_q        <= err_d;
      frame_cnt_q  <= frame_cnt_d;
    end
  end

  assign wr_ready   = wr_ready_q;
  assign o_in_valid = out_valid_q;
  assign o_flag     = out_flag_q;
  assign o_data     = out_data_q;
  assign frame_done = frame_done_q;
  assign err        = err_q;
  assign frame_cnt  = frame_cnt_q;

`ifdef SEQ_STALL_CNT_EN
  logic [15:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid_q && !i_in_ready && (stall_cnt_q != 16'hFFFF))
      stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_mimo_input_sequencer.sv
// Randomized bench for mimo_input_sequencer against a frame-order reference model.
module tb_mimo_input_sequencer;
  localparam int W   = 128;
  localparam int FD  = 4;
  localparam int NCH = 4;
  localparam int NDL = 11;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         wr_valid = 1'b0;
  logic         wr_ready;
  logic         wr_flag = 1'b0;
  logic [W-1:0] wr_data = '0;
  logic         o_in_valid;
  logic         o_flag;
  logic [W-1:0] o_data;
  logic         i_in_ready = 1'b1;
  logic         frame_done;
  logic         err;
  logic [7:0]   frame_cnt;
  logic [15:0]  stall_cnt;

  mimo_input_sequencer #(
    .I_WIDTH(16), .FIFO_DEPTH(FD), .NUM_CH_WORDS(NCH), .FRAME_DATA_LEN(NDL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .wr_flag(wr_flag), .wr_data(wr_data), .o_in_valid(o_in_valid),
    .o_flag(o_flag), .o_data(o_data), .i_in_ready(i_in_ready),
    .frame_done(frame_done), .err(err), .frame_cnt(frame_cnt), .stall_cnt(stall_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic         flag;
    logic         last;
    logic [W-1:0] data;
  } exp_t;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  bit   m_in_data;
  int   m_pos, m_err, m_frames, n_acc, dut_errs, dut_fd;
  bit   fd_pending, prev_stall;
  logic prev_flag;
  logic [W-1:0] prev_data;
  int   rdy_mode = 0;
  bit   bp_done;

  task automatic chk(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rw();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Reference: a frame is NCH channel words then NDL data words, judged in acceptance order.
  task automatic model_accept(input logic f, input logic [W-1:0] d);
    exp_t e;
    n_acc++;
    e.data = d;
    e.flag = f;
    e.last = 1'b0;
    if (!m_in_data) begin
      if (f) begin
        exp_q.push_back(e);
        m_pos++;
        if (m_pos == NCH) begin m_in_data = 1; m_pos = 0; end
      end else begin
        m_err++;
      end
    end else if (!f) begin
      m_pos++;
      e.last = (m_pos == NDL);
      exp_q.push_back(e);
      if (m_pos == NDL) begin m_in_data = 0; m_pos = 0; end
    end else begin
      m_err++;
      exp_q.push_back(e);
      m_in_data = 0;
      m_pos = 1;
    end
  endtask

  task automatic flush_model();
    exp_q.delete();
    m_in_data = 0; m_pos = 0; m_err = 0; m_frames = 0; n_acc = 0;
    dut_errs = 0; dut_fd = 0; fd_pending = 0; prev_stall = 0;
  endtask

  // Monitor: sample at negedge what will happen at the next posedge.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (fd_pending) m_frames++;
      chk("frame_done", W'(frame_done), W'(fd_pending));
      chk("frame_cnt", W'(frame_cnt), W'(m_frames[7:0]));
      if (frame_done) dut_fd++;
      if (err) dut_errs++;
      if (prev_stall) begin
        chk("hold_valid", W'(o_in_valid), W'(1));
        chk("hold_data", o_data, prev_data);
        chk("hold_flag", W'(o_flag), W'(prev_flag));
      end
      fd_pending = 0;
      if (wr_valid && wr_ready) model_accept(wr_flag, wr_data);
      if (o_in_valid && i_in_ready) begin
        if (exp_q.size() == 0) begin
          chk("spurious_xfer", W'(exp_q.size()), W'(1));
        end else begin
          mon_e = exp_q.pop_front();
          chk("out_data", o_data, mon_e.data);
          chk("out_flag", W'(o_flag), W'(mon_e.flag));
          fd_pending = mon_e.last;
        end
      end
      prev_stall = o_in_valid && !i_in_ready;
      prev_data  = o_data;
      prev_flag  = o_flag;
    end
  end

  initial forever begin
    @(posedge clk); #1;
    case (rdy_mode)
      0:       i_in_ready = 1'b1;
      1:       i_in_ready = ($urandom_range(0, 3) != 0);
      default: i_in_ready = 1'b0;
    endcase
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic send(input logic f, input logic [W-1:0] d);
    int t;
    bit done;
    t = 0;
    done = 0;
    wr_valid = 1'b1; wr_flag = f; wr_data = d;
    while (!done && t < 2000) begin
      @(negedge clk);
      t++;
      if (wr_ready) begin @(posedge clk); #1; done = 1; end
    end
    if (!done) chk("send_timeout", W'(t), W'(0));
    wr_valid = 1'b0;
  endtask

  task automatic send_frame(input bit gaps);
    for (int i = 0; i < NCH + NDL; i++) begin
      send(i < NCH, rw());
      if (gaps && $urandom_range(0, 3) == 0) begin @(posedge clk); #1; end
    end
  endtask

  task automatic drain();
    int t;
    t = 0;
    rdy_mode = 0; i_in_ready = 1'b1;
    while (exp_q.size() != 0 && t < 5000) begin @(posedge clk); #1; t++; end
    chk("drain", W'(exp_q.size()), W'(0));
    repeat (FD + 4) begin @(posedge clk); #1; end
  endtask

  task automatic apply_reset();
    wr_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_valid_async", W'(o_in_valid), W'(0));
    chk("rst_frame_cnt", W'(frame_cnt), W'(0));
    flush_model();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_wr_ready", W'(wr_ready), W'(1));
    chk("rst_o_flag", W'(o_flag), W'(0));
    chk("rst_o_data", o_data, W'(0));
    chk("rst_err", W'(err), W'(0));
    chk("rst_frame_done", W'(frame_done), W'(0));
    chk("rst_stall_cnt", W'(stall_cnt), W'(0));
    @(posedge clk); #1;
  endtask

  initial begin
    int t;
    // Nominal frame with 1-cycle presentation latency
    rdy_mode = 0; i_in_ready = 1'b1;
    apply_reset();
    send(1'b1, W'(1));
    chk("lat_not_yet", W'(o_in_valid), W'(0));
    @(posedge clk); #1;
    chk("lat_valid", W'(o_in_valid), W'(1));
    chk("lat_data", o_data, W'(1));
    chk("lat_flag", W'(o_flag), W'(1));
    for (int i = 2; i <= 15; i++) send(i <= NCH, W'(i));
    drain();
    chk("nom_frames", W'(frame_cnt), W'(1));
    chk("nom_fd", W'(dut_fd), W'(1));
    chk("nom_err", W'(dut_errs), W'(0));

    // Backpressure: hold ready low for 6 stalled cycles
    rdy_mode = 2; i_in_ready = 1'b0;
    apply_reset();
    bp_done = 0;
    fork
      begin
        for (int i = 1; i <= 8; i++) send(i <= NCH, W'(i));
        bp_done = 1;
      end
    join_none
    t = 0;
    while (!o_in_valid && t < 50) begin @(posedge clk); #1; t++; end
    chk("bp_valid", W'(o_in_valid), W'(1));
    repeat (6) @(posedge clk);
    #1;
    chk("bp_wr_ready", W'(wr_ready), W'(0));
    chk("bp_accepted", W'(n_acc), W'(FD + 1));
    chk("bp_data_held", o_data, W'(1));
`ifdef SEQ_STALL_CNT_EN
    chk("bp_stall_cnt", W'(stall_cnt), W'(6));
`endif
    rdy_mode = 0; i_in_ready = 1'b1;
    t = 0;
    while (!bp_done && t < 200) begin @(posedge clk); #1; t++; end
    chk("bp_sender", W'(bp_done), W'(1));
    for (int i = 9; i <= 15; i++) send(1'b0, W'(i));
    drain();
    chk("bp_frames", W'(frame_cnt), W'(1));

    // Data word while expecting channel words is dropped
    apply_reset();
    send(1'b0, W'('hAA));
    send_frame(1'b0);
    drain();
    chk("ord_err", W'(dut_errs), W'(1));
    chk("ord_frames", W'(frame_cnt), W'(1));

    // Early channel word restarts the frame
    apply_reset();
    for (int i = 0; i < NCH; i++) send(1'b1, rw());
    for (int i = 0; i < 5; i++) send(1'b0, rw());
    send(1'b1, W'('hBB));
    for (int i = 0; i < NCH - 1; i++) send(1'b1, rw());
    drain();
    chk("early_err", W'(dut_errs), W'(1));
    chk("early_frames_mid", W'(frame_cnt), W'(0));
    for (int i = 0; i < NDL; i++) send(1'b0, rw());
    drain();
    chk("early_frames", W'(frame_cnt), W'(1));

    // Reset while the output register holds word 7
    apply_reset();
    for (int i = 1; i <= 6; i++) send(i <= NCH, W'(i));
    repeat (3) begin @(posedge clk); #1; end
    rdy_mode = 2; i_in_ready = 1'b0;
    send(1'b0, W'(7));
    repeat (2) begin @(posedge clk); #1; end
    chk("mid_valid", W'(o_in_valid), W'(1));
    chk("mid_data", o_data, W'(7));
    apply_reset();
    rdy_mode = 0; i_in_ready = 1'b1;
    send_frame(1'b0);
    drain();
    chk("mid_after_frames", W'(frame_cnt), W'(1));
    chk("mid_after_err", W'(dut_errs), W'(0));

    // 256 frames under random backpressure wrap the frame counter
    apply_reset();
    rdy_mode = 1;
    for (int f = 0; f < 256; f++) begin
      send_frame(1'b1);
      rdy_mode = 1;
    end
    drain();
    chk("wrap_frames", W'(frame_cnt), W'(0));
    chk("wrap_fd", W'(dut_fd), W'(256));
    chk("wrap_err", W'(dut_errs), W'(0));

    // Random flag stream against the model
    rdy_mode = 1;
    for (int i = 0; i < 300; i++) send(($urandom_range(0, 2) == 0), rw());
    drain();
    chk("rand_err", W'(dut_errs), W'(m_err));
    chk("rand_fd", W'(dut_fd), W'(m_frames));
`ifndef SEQ_STALL_CNT_EN
    chk("stall_cnt_off", W'(stall_cnt), W'(0));
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mimo_input_sequencer.md
Name: mimo_input_sequencer

Overview:
- Transmit-side feeder for the MIMO detector's input port; drives its i_in_valid / flagChannelorData / InData and honours its o_in_ready.
- Buffers channel and received-vector words from an upstream source in a small FIFO.
- Enforces frame order: NUM_CH_WORDS channel words (flag=1), then FRAME_DATA_LEN data words (flag=0).
- Reports frame completion and protocol errors.

Parameters:
I_WIDTH, 16, bits per real/imag component (Q6.10)
DATA_W, I_WIDTH*8, word width (4 complex entries)
FIFO_DEPTH, 4, input FIFO entries, power of two >= 2
NUM_CH_WORDS, 4, channel words per frame
FRAME_DATA_LEN, 11, data words per frame

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
wr_valid  in  1  upstream word valid
wr_ready  out  1  FIFO not full
wr_flag  in  1  1=channel word, 0=data word
wr_data  in  DATA_W  upstream word
o_in_valid  out  1  to detector i_in_valid
o_flag  out  1  to detector flagChannelorData
o_data  out  DATA_W  to detector InData
i_in_ready  in  1  from detector o_in_ready
frame_done  out  1  one-cycle pulse on last data word accepted
err  out  1  one-cycle pulse on order violation
frame_cnt  out  8  completed frames, wraps 255->0
stall_cnt  out  16  see Optional Feature

Behaviour:
- Reset (async assert, sync release): FIFO empty, state S_CHAN, counters 0, wr_ready=1 (once released), o_in_valid=0, o_flag=0, o_data=0, frame_done=0, err=0, frame_cnt=0, stall_cnt=0.
- Upstream write when wr_valid && wr_ready at posedge. wr_ready = !full, registered. Writes while full are ignored.
- Downstream transfer when o_in_valid && i_in_ready at posedge. o_flag/o_data are held stable while o_in_valid && !i_in_ready. o_in_valid never drops without a transfer.
- Output register: loads the FIFO head when empty, or in the same cycle as a transfer. A word written into an empty FIFO with an empty output register is presented on o_in_valid the next cycle (1-cycle latency). Back-to-back transfers sustain 1 word/cycle.
- Simultaneous FIFO write and read when full: the read frees a slot, but wr_ready reflects the pre-edge full flag; no data loss.
- Order check is applied when the FIFO head is popped into the output register.
- State S_CHAN (ch_cnt):
  - flag=1: forward; ch_cnt++; at NUM_CH_WORDS go to S_DATA with data_cnt=0.
  - flag=0: drop the word, pulse err, stay in S_CHAN.
- State S_DATA (data_cnt):
  - flag=0: forward; data_cnt++.
  - flag=1 (early new channel): pulse err, forward the word as channel word 1 of a new frame, ch_cnt=1, go to S_CHAN. frame_cnt is not incremented.
- frame_done pulses the cycle after the FRAME_DATA_LEN-th data word is accepted downstream (transfer, not pop). On that pulse, frame_cnt++.
- Phase returns to S_CHAN when the last data word is popped.
- Asynchronous reset mid-frame discards the FIFO and output register contents; o_in_valid drops immediately.

Optional Feature:
- Macro SEQ_STALL_CNT_EN.
- Defined: stall_cnt increments each cycle o_in_valid && !i_in_ready, saturates at 16'hFFFF, and clears on reset.
- Undefined: stall_cnt is a constant 0 and no counter logic is built. The port exists in both builds.

Test Plan:
1. Nominal frame: 4 flag=1 words then 11 flag=0 words (words 0x1..0xF), i_in_ready=1 throughout -> 15 transfers in order, flags 1,1,1,1,0x11. frame_done pulses once, frame_cnt=1, err never asserted.
2. Backpressure: i_in_ready held low 6 cycles after first o_in_valid, 8 words offered -> wr_ready falls after FIFO_DEPTH+1 words held. o_data stays at word 0x1, no loss, order preserved after release. With SEQ_STALL_CNT_EN, stall_cnt=6.
3. Order error: flag=0 word 0xAA sent first in S_CHAN -> word not forwarded, err pulse 1 cycle, next 4 flag=1 words forwarded normally.
4. Early channel: after 4 channel words + 5 data words, a flag=1 word 0xBB -> err pulse, 0xBB forwarded with o_flag=1, 3 more channel words then 11 data words needed for frame_done. frame_cnt unchanged until then.
5. Reset mid-frame: rst_n low while o_in_valid=1 holding word 7 -> o_in_valid=0 immediately, frame_cnt=0, state S_CHAN. Next frame processes correctly.
6. Wrap: 256 complete frames -> frame_cnt returns to 0, frame_done pulses 256 times.
